// File: rtl/sched_pkg.sv
// Shared types and helpers for the round-robin scheduler family.
package sched_pkg;

    // Widest requester vector the helpers below can handle.
    localparam int MAX_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // Rotate the low w bits of a one-hot vector left by one; MSB wraps to bit 0.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1) begin
                r[i+1] = v[i];
            end else if (i == w - 1) begin
                r[0] = v[i];
            end
        end
        return r;
    endfunction

    // Binary index of a one-hot vector; zero vector maps to index 0.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_W-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (v[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set bit of req at or above
// the one-hot token, wrapping around. Zero output when req is all-zero.
module rr_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] token,
    output logic [WIDTH-1:0] pick
);
    import sched_pkg::*;

    logic [2*WIDTH-1:0] dbl_req;
    logic [2*WIDTH-1:0] dbl_sub;
    logic [2*WIDTH-1:0] dbl_gnt;

    // Duplicating req makes the wrap a plain upward search; subtracting the
    // token flips the run of zeros up to the first hit, isolating that bit.
    always_comb begin
        dbl_req = {req, req};
        dbl_sub = dbl_req - {{WIDTH{1'b0}}, token};
        dbl_gnt = dbl_req & ~dbl_sub;
        pick    = dbl_gnt[WIDTH-1:0] | dbl_gnt[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/round_robin_scheduler.sv
// Round-robin arbiter with hold-until-done ownership, zero-bubble handover
// and a hold-time watchdog that revokes overstaying grants.
module round_robin_scheduler
    import sched_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         req,
    input  logic                     done,
    output logic [WIDTH-1:0]         grant,
    output logic [$clog2(WIDTH)-1:0] grant_idx,
    output logic                     busy,
    output logic [WIDTH-1:0]         token,
    output logic                     timeout
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    sched_state_t     state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IW-1:0]    grant_idx_q, grant_idx_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] token_q, token_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] owner_next_tok;
    logic [WIDTH-1:0] pick_req, pick_tok, pick;
    logic             owner_req;
    logic             expire;
    logic             release_c;

    // Release decode; expiry only counts as a timeout when nothing else ends the grant.
    always_comb begin
        owner_next_tok = WIDTH'(rotl1(MAX_W'(grant_q), WIDTH));
        owner_req      = |(req & grant_q);
        release_c      = (state_q == GRANT) && (done || !owner_req || expire);
        pick_req       = (state_q == GRANT) ? (req & ~grant_q) : req;
        pick_tok       = (state_q == GRANT) ? owner_next_tok : token_q;
    end

    rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req   (pick_req),
        .token (pick_tok),
        .pick  (pick)
    );

    generate
        if (MAX_HOLD > 0) begin : g_wdog
            logic [CW-1:0] hold_cnt_q, hold_cnt_d;

            // Hold counter: counts consecutive cycles of the current owner.
            always_comb begin
                hold_cnt_d = '0;
                if (state_q == GRANT && !release_c) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            // Hold counter register.
            always_ff @(posedge clock) begin
                if (reset) begin
                    hold_cnt_q <= '0;
                end else begin
                    hold_cnt_q <= hold_cnt_d;
                end
            end

            assign expire = (state_q == GRANT) && (hold_cnt_q == CW'(MAX_HOLD - 1));
        end else begin : g_no_wdog
            assign expire = 1'b0;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = GRANT;
            GRANT:   if (release_c && !(|pick)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next grant, token and timeout pulse.
    always_comb begin
        grant_d   = grant_q;
        token_d   = token_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = pick;
            end
            GRANT: begin
                if (release_c) begin
                    token_d   = owner_next_tok;
                    grant_d   = pick;
                    timeout_d = expire && !done && owner_req;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
        grant_idx_d = IW'(onehot_to_idx(MAX_W'(grant_d)));
        busy_d      = |grant_d;
    end

    // Output and token registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            token_q     <= WIDTH'(1);
            timeout_q   <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            token_q     <= token_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign token     = token_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Directed bench for round_robin_scheduler (WIDTH=4, MAX_HOLD=8).
module tb_round_robin_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic [3:0] token;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    round_robin_scheduler #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .token     (token),
        .timeout   (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_grant",   32'(grant),     32'h0);
        check("rst_idx",     32'(grant_idx), 32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_token",   32'(token),     32'h1);
        check("rst_timeout", 32'(timeout),   32'h0);
        reset = 1'b0;

        // Handover
        req = 4'b1010;
        tick();
        check("ho_grant1", 32'(grant),     32'b0010);
        check("ho_idx1",   32'(grant_idx), 32'd1);
        check("ho_busy1",  32'(busy),      32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("ho_grant2", 32'(grant),     32'b1000);
        check("ho_idx2",   32'(grant_idx), 32'd3);
        check("ho_token2", 32'(token),     32'b0100);
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;
        check("ho_grant3", 32'(grant), 32'b0000);
        check("ho_token3", 32'(token), 32'b0001);
        check("ho_busy3",  32'(busy),  32'h0);

        // done outside GRANT is ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        check("idle_done_token", 32'(token), 32'b0001);

        // Wrap-around
        req = 4'b0100;
        tick();
        check("wr_grant0", 32'(grant), 32'b0100);
        req = 4'b0000;
        tick();
        check("wr_idle",  32'(grant), 32'b0000);
        check("wr_token", 32'(token), 32'b1000);
        req = 4'b0101;
        tick();
        check("wr_grant1", 32'(grant), 32'b0001);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wr_grant2", 32'(grant), 32'b0100);
        check("wr_token2", 32'(token), 32'b0010);
        req = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Watchdog: owner holds 8 cycles, non-owner req changes ignored
        req = 4'b0100;
        tick();
        check("wd_grant_c1", 32'(grant), 32'b0100);
        for (int i = 2; i <= 8; i++) begin
            req = (i == 4) ? 4'b0101 : 4'b0100;
            tick();
            check($sformatf("wd_grant_c%0d", i), 32'(grant), 32'b0100);
            check($sformatf("wd_to_c%0d", i), 32'(timeout), 32'h0);
        end
        tick();
        check("wd_grant_rel", 32'(grant),   32'b0000);
        check("wd_timeout",   32'(timeout), 32'h1);
        check("wd_token",     32'(token),   32'b1000);
        req = 4'b0000;
        tick();
        check("wd_timeout_end", 32'(timeout), 32'h0);
        check("wd_idle",        32'(grant),   32'b0000);

        // Collision: done on expiry cycle
        req = 4'b0010;
        tick();
        check("co_grant", 32'(grant), 32'b0010);
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("co_grant_c8", 32'(grant), 32'b0010);
        done = 1'b1;
        req  = 4'b0011;
        tick();
        done = 1'b0;
        check("co_timeout", 32'(timeout), 32'h0);
        check("co_grant2",  32'(grant),   32'b0001);
        check("co_token",   32'(token),   32'b0100);

        // Owner drops req mid-grant
        req = 4'b1000;
        tick();
        check("drop_grant",   32'(grant),     32'b1000);
        check("drop_idx",     32'(grant_idx), 32'd3);
        check("drop_timeout", 32'(timeout),   32'h0);

        // Reset mid-grant
        req = 4'b0010;
        tick();
        check("mr_grant", 32'(grant), 32'b0010);
        reset = 1'b1;
        tick();
        check("mr_grant0",  32'(grant),   32'b0000);
        check("mr_token",   32'(token),   32'b0001);
        check("mr_timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        check("mr_grant1", 32'(grant),     32'b0001);
        check("mr_idx1",   32'(grant_idx), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
